mul_handshake_ctrl: RTL

Request/response controller on the initiator side of the multiplier's start/done interface. It accepts an operand pair on a valid/ready input channel, launches one multiplication with a single-cycle start pulse, and waits for the datapath's completion pulse. It then captures the 2×WIDTH product and presents it on a valid/ready output channel. It sits between the system bus adapter and the radix-16 Booth datapath and its done generator.

---
 rtl/mul_pkg.sv | 14 +
 rtl/mul_watchdog.sv | 34 +++
 rtl/mul_handshake_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared constants and controller state type for the multiplier slice.
package mul_pkg;

  localparam int MULCYCLES          = 8;
  localparam int MUL_TIMEOUT_CYCLES = 2 * MULCYCLES + 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/mul_watchdog.sv
// WAIT-state cycle counter; expired is high on the cycle whose closing edge
// completes TIMEOUT_CYCLES consecutive WAIT cycles.
module mul_watchdog
  import mul_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = MUL_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_wait,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Held at zero outside WAIT, so every entry into WAIT starts from zero.
  always_comb begin
    cnt_d = in_wait ? cnt_q + CW'(1) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = in_wait && (cnt_q == LAST);

endmodule

// File: rtl/mul_handshake_ctrl.sv
// Initiator-side start/done controller with valid/ready operand and result channels.
// Optional WAIT watchdog enabled by defining MUL_CTRL_TIMEOUT_EN.
module mul_handshake_ctrl
  import mul_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = MUL_TIMEOUT_CYCLES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               mul_start,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic               mul_done,
  input  logic [2*WIDTH-1:0] mul_product,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product,
  output logic               out_error,
  output logic               busy
);

  ctrl_state_e        state_q, state_d;
  logic [WIDTH-1:0]   mul_a_q, mul_a_d;
  logic [WIDTH-1:0]   mul_b_q, mul_b_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

`ifdef MUL_CTRL_TIMEOUT_EN
  logic err_q, err_d;
  logic timeout_hit;

  mul_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_wait(state_q == WAIT),
    .expired(timeout_hit)
  );

  assign out_error = err_q;
`else
  assign out_error = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    prod_d  = prod_q;
`ifdef MUL_CTRL_TIMEOUT_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mul_a_d = in_a;
          mul_b_d = in_b;
          state_d = START;
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        // A done pulse on the expiry edge still counts as a normal completion.
        if (mul_done) begin
          prod_d  = mul_product;
          state_d = RESP;
`ifdef MUL_CTRL_TIMEOUT_EN
          err_d   = 1'b0;
        end else if (timeout_hit) begin
          prod_d  = '0;
          err_d   = 1'b1;
          state_d = RESP;
`endif
        end
      end
      RESP: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mul_a_q <= '0;
      mul_b_q <= '0;
      prod_q  <= '0;
`ifdef MUL_CTRL_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      prod_q  <= prod_d;
`ifdef MUL_CTRL_TIMEOUT_EN
      err_q   <= err_d;
`endif
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign mul_start   = (state_q == START);
  assign out_valid   = (state_q == RESP);
  assign busy        = (state_q != IDLE);
  assign mul_a       = mul_a_q;
  assign mul_b       = mul_b_q;
  assign out_product = prod_q;

endmodule
